// File: rtl/uart_imem_loader.sv
// Turns the UART RX byte stream into little-endian 32-bit words and writes them into instruction memory from address 0.
// Holds the core in reset until the terminator word arrives.
module uart_imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_break,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  write_done,
  output logic                  core_rst,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      IDLE_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_COMMIT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word;
  logic [CNT_W-1:0]      r_idle;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_done;
  logic                  r_core_rst;
  logic                  r_frame_err;
  logic                  r_overflow;

  logic                  w_active;
  logic                  w_break;
  logic                  w_accept;
  logic                  w_last_byte;
  logic [31:0]           w_word;
  logic                  w_is_end;
  logic                  w_full;
  logic                  w_commit;
  logic                  w_finish;
  logic                  w_partial;
  logic                  w_timeout;

  // BREAK beats a simultaneous byte; nothing is taken once loading has finished.
  assign w_active    = (r_state != S_DONE);
  assign w_break     = w_active & uart_rx_break;
  assign w_accept    = w_active & uart_rx_valid & ~uart_rx_break;
  assign w_last_byte = w_accept & (r_byte_idx == 2'd3);
  assign w_word      = {uart_rx_data, r_word};
  assign w_is_end    = (w_word == END_WORD);
  assign w_full      = (r_word_count == CAPACITY);
  assign w_commit    = w_last_byte & ~w_is_end & ~w_full;
  assign w_finish    = w_last_byte & (w_is_end | w_full);
  assign w_partial   = (r_byte_idx != 2'd0);
  assign w_timeout   = w_active & ~w_accept & ~w_break & w_partial & (r_idle == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD, S_COMMIT: begin
        if (w_last_byte) begin
          w_state_nxt = w_finish ? S_DONE : S_COMMIT;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Byte assembly, BREAK and inter-byte timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx  <= 2'd0;
      r_word      <= 24'd0;
      r_idle      <= '0;
      r_frame_err <= 1'b0;
    end else if (w_break) begin
      r_byte_idx <= 2'd0;
      r_idle     <= '0;
      if (w_partial) begin
        r_frame_err <= 1'b1;
      end
    end else if (w_accept) begin
      case (r_byte_idx)
        2'd0:    r_word[7:0]   <= uart_rx_data;
        2'd1:    r_word[15:8]  <= uart_rx_data;
        2'd2:    r_word[23:16] <= uart_rx_data;
        default: r_word        <= r_word;
      endcase
      r_byte_idx <= r_byte_idx + 2'd1;
      r_idle     <= '0;
    end else if (w_timeout) begin
      r_byte_idx  <= 2'd0;
      r_idle      <= '0;
      r_frame_err <= 1'b1;
    end else if (w_active && w_partial) begin
      r_idle <= r_idle + IDLE_ONE;
    end else begin
      r_idle <= '0;
    end
  end

  // Memory write port, word counter and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_core_rst   <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_we <= w_commit;
      if (w_commit) begin
        r_wdata <= w_word;
      end
      if (r_state == S_COMMIT) begin
        r_addr       <= r_addr + ADDR_ONE;
        r_word_count <= r_word_count + COUNT_ONE;
      end
      if (w_finish) begin
        r_done     <= 1'b1;
        r_core_rst <= 1'b0;
      end
      if (w_last_byte && !w_is_end && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_word_count;
  assign write_done = r_done;
  assign core_rst   = r_core_rst;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomised scoreboard bench for uart_imem_loader; a queue-based byte model predicts writes and flags.
module tb_uart_imem_loader;

  localparam int unsigned AW  = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx_valid;
  logic [7:0]    uart_rx_data;
  logic          uart_rx_break;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          write_done;
  logic          core_rst;
  logic          frame_err;
  logic          overflow;

  uart_imem_loader #(
    .ADDR_WIDTH     (AW),
    .END_WORD       (32'hFFFF_FFFF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .word_count    (word_count),
    .write_done    (write_done),
    .core_rst      (core_rst),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_pass  = 0;
  int  n_total = 0;

  // Reference model: pending bytes of the current word plus sticky flags.
  byte unsigned m_bytes[$];
  int           m_idle;
  int           m_count;
  bit           m_done;
  bit           m_ferr;
  bit           m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_idle  = 0;
    m_count = 0;
    m_done  = 0;
    m_ferr  = 0;
    m_ovf   = 0;
  endtask

  task automatic model_word();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) w = w + (32'(m_bytes[i]) << (8 * i));
    m_bytes.delete();
    if (w == 32'hFFFF_FFFF) begin
      m_done = 1;
    end else if (m_count == int'(CAP)) begin
      m_ovf  = 1;
      m_done = 1;
    end else begin
      exp_q.push_back('{addr: AW'(m_count), data: w});
      m_count++;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit b);
    if (m_done) return;
    if (b) begin
      if (m_bytes.size() != 0) m_ferr = 1;
      m_bytes.delete();
      m_idle = 0;
    end else if (v) begin
      m_bytes.push_back(d);
      m_idle = 0;
      if (m_bytes.size() == 4) model_word();
    end else if (m_bytes.size() != 0) begin
      m_idle++;
      if (m_idle >= int'(TO)) begin
        m_bytes.delete();
        m_ferr = 1;
        m_idle = 0;
      end
    end
  endtask

  // One clock of stimulus: drive on the falling edge, DUT samples on the next rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit b);
    uart_rx_valid = v;
    uart_rx_data  = d;
    uart_rx_break = b;
    model_step(v, d, b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) step(1'b1, w[8*i +: 8], 1'b0);
    idle(gap);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"},         64'(imem_we),    64'(0));
    chk({tag, "_addr"},       64'(imem_addr),  64'(0));
    chk({tag, "_wdata"},      64'(imem_wdata), 64'(0));
    chk({tag, "_word_count"}, 64'(word_count), 64'(0));
    chk({tag, "_write_done"}, 64'(write_done), 64'(0));
    chk({tag, "_core_rst"},   64'(core_rst),   64'(1));
    chk({tag, "_frame_err"},  64'(frame_err),  64'(0));
    chk({tag, "_overflow"},   64'(overflow),   64'(0));
  endtask

  task automatic checkpoint(input string tag);
    idle(3);
    chk({tag, "_word_count"}, 64'(word_count),    64'(m_count));
    chk({tag, "_write_done"}, 64'(write_done),    64'(m_done));
    chk({tag, "_core_rst"},   64'(core_rst),      64'(!m_done));
    chk({tag, "_frame_err"},  64'(frame_err),     64'(m_ferr));
    chk({tag, "_overflow"},   64'(overflow),      64'(m_ovf));
    chk({tag, "_pending"},    64'(exp_q.size()),  64'(0));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h7FFF_FFFF;
    return w;
  endfunction

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0d data %08h required no write (t=%0t)",
                 imem_addr, imem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(mon_e.addr));
        chk("write_data", 64'(imem_wdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    logic [31:0] w;
    int          gap;
    rst           = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;
    model_reset();
    do_reset();
    check_reset_values("reset");

    // Single word
    send_word(32'hFB01_0113, 0);
    checkpoint("single");

    // Program load with terminator, then a word that must be ignored
    do_reset();
    for (int i = 0; i < 3; i++) send_word(rand_word(), i);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk("done_before_last_ff", 64'(write_done), 64'(0));
    step(1'b1, 8'hFF, 1'b0);
    chk("done_after_last_ff", 64'(write_done), 64'(1));
    chk("core_rst_after_last_ff", 64'(core_rst), 64'(0));
    send_word(rand_word(), 2);
    checkpoint("program");

    // Longest allowed gap inside a word
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    checkpoint("gap_edge");

    // Timeout discards the partial word
    do_reset();
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    idle(20);
    send_word(32'h0481_2623, 0);
    checkpoint("timeout");

    // BREAK coincident with a valid byte
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h04, 1'b1);
    send_word(rand_word(), 0);
    checkpoint("break");

    // Overflow after filling all words, back to back
    do_reset();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 0);
    checkpoint("overflow");

    // Reset in the middle of loading
    do_reset();
    send_word(rand_word(), 0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    do_reset();
    check_reset_values("midreset");
    send_word(rand_word(), 0);
    checkpoint("after_midreset");

    // Random streams with gaps, timeouts, breaks and occasional terminators
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < 8; k++) begin
        w = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : rand_word();
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 24) == 0) step($urandom_range(0, 1) == 1, 8'h00, 1'b1);
          step(1'b1, w[8*i +: 8], 1'b0);
          gap = ($urandom_range(0, 14) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                             : int'($urandom_range(0, 2));
          idle(gap);
        end
      end
      checkpoint("random");
    end

    idle(4);
    chk("final_pending", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Assembles the byte stream from the UART receiver into 32-bit little-endian instruction words and writes them sequentially into instruction memory from address 0. It holds the processor core in reset during loading and releases it when the terminator word 0xFFFFFFFF arrives. It sits directly downstream of the UART RX block and upstream of the instruction memory write port inside `wrapper`.

## Interface

Parameters:
- `ADDR_WIDTH`, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- `END_WORD`, 32'hFFFFFFFF, terminator word; it ends loading and is never written.
- `TIMEOUT_CYCLES`, 200000, idle clocks allowed between bytes of one word before the partial word is discarded.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `uart_rx_valid` input 1: one-cycle strobe; `uart_rx_data` holds a valid byte.
- `uart_rx_data` input 8: received byte.
- `uart_rx_break` input 1: BREAK detected on the line.
- `imem_we` output 1: one-cycle instruction memory write strobe.
- `imem_addr` output ADDR_WIDTH: word address for the write.
- `imem_wdata` output 32: assembled instruction word.
- `word_count` output ADDR_WIDTH+1: number of words written so far.
- `write_done` output 1: load complete; sticky until `rst`.
- `core_rst` output 1: holds the core in reset; equals `~write_done`.
- `frame_err` output 1: sticky; a partial word was discarded because of a timeout or BREAK.
- `overflow` output 1: sticky; a non-terminator word arrived after memory was full.

## Operation

- States: LOAD, COMMIT, DONE. Reset enters LOAD.
- **Byte capture.** A byte is accepted in any cycle where `uart_rx_valid=1`, state is not DONE, and `uart_rx_break=0`.
  - Byte k (k=0..3) goes to `word[8k+7:8k]`, so the first byte is the LSB.
  - A 2-bit byte index increments on each accepted byte and wraps 3→0.
- **Word complete (4th byte).**
  - If the word equals END_WORD: go to DONE; `write_done` becomes 1.
  - Else, if `word_count == 2^ADDR_WIDTH`: set `overflow`, go to DONE, set `write_done`. Nothing is written.
  - Else: load `imem_wdata` with the word and go to COMMIT.
- **COMMIT (exactly one cycle).**
  - `imem_we=1`, with `imem_addr` and `imem_wdata` stable.
  - On the next edge: `imem_addr` increments (wraps to 0 at the top; harmless because of the overflow check), `word_count` increments, return to LOAD.
  - A byte arriving during COMMIT is accepted as byte 0 of the next word.
- **BREAK.** If `uart_rx_break=1` in LOAD or COMMIT, the byte index clears. If it was nonzero, `frame_err` is set.
  - A simultaneous valid byte is discarded; BREAK wins.
  - A COMMIT already in progress still completes.
- **Timeout.** The idle counter resets on each accepted byte and counts while the byte index ≠ 0.
  - At TIMEOUT_CYCLES-1 the byte index clears and `frame_err` is set.
  - The counter is held at 0 while the byte index is 0.
- **DONE.** All UART input is ignored. Outputs hold until `rst`.
- **Reset mid-operation.** Any partial word and the address are lost. Loading restarts at address 0.

## Timing

- Reset values: `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `word_count=0`, `write_done=0`, `core_rst=1`, `frame_err=0`, `overflow=0`, byte index 0, idle counter 0.
- 4th byte accepted at edge N:
  - `imem_we=1` during cycle N+1.
  - Address and count are updated at edge N+2.
- Terminator accepted at edge N: `write_done=1` and `core_rst=0` from cycle N+1.
- Maximum byte rate: one accepted byte per clock. There is no backpressure and no byte is ever dropped in LOAD or COMMIT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Single word.** Bytes 13,01,01,FB → one `imem_we` pulse with addr 0 and data 0xFB010113, then `word_count=1`.
- **Program load with terminator.** 3 words followed by FF,FF,FF,FF → writes to addr 0,1,2 in order, then `write_done=1` and `core_rst=0` one cycle after the last FF. A 5th word sent afterwards produces no write.
- **Timeout.** With TIMEOUT_CYCLES=16, send 2 bytes, wait 20 cycles, then send 4 bytes 23,26,81,04 → `frame_err=1` and a single write of 0x04812623 at addr 0.
- **BREAK.** Send 3 bytes, then pulse BREAK in the same cycle as a valid byte → no write, `frame_err=1`; the next 4 bytes form word 0.
- **Overflow.** With ADDR_WIDTH=2, send 5 non-terminator words → 4 writes (addr 0..3), then `overflow=1` and `write_done=1` with no 5th write.
- **Reset mid-load.** Assert `rst` after 6 bytes → all outputs return to their reset values; the next 4 bytes are written to addr 0.
